// File: rtl/rv_fetch_pkg.sv
// rv_fetch_pkg: shared types and helpers for the RV32I fetch stage.
// Queue entry layout, NOP encoding and pointer sizing.
package rv_fetch_pkg;

  localparam int PC_W = 32;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            filled;
  } fetch_entry_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/rv_fetch_unit_queue.sv
// fetch_queue: in-order instruction queue with allocate/fill/pop/flush.
// Pointers carry a wrap bit so full and empty are distinct.
module fetch_queue
  import rv_fetch_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int QDEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RSTn,
  input  logic                       flush,
  input  logic                       alloc,
  input  logic [ADDR_W-1:0]          alloc_pc,
  input  logic                       fill,
  input  logic [31:0]                fill_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic                       head_valid,
  output logic [ptr_w(QDEPTH):0]     count,
  output logic [ptr_w(QDEPTH):0]     unfilled
);

  localparam int PW = ptr_w(QDEPTH);
  localparam logic [PW:0] ONE = (PW+1)'(1);

  fetch_entry_t ent [QDEPTH];

  logic [PW:0] hd;
  logic [PW:0] tl;
  logic [PW:0] fp;

  logic [PW-1:0] hd_i;
  logic [PW-1:0] tl_i;
  logic [PW-1:0] fp_i;

  assign hd_i = hd[PW-1:0];
  assign tl_i = tl[PW-1:0];
  assign fp_i = fp[PW-1:0];

  assign count    = tl - hd;
  assign unfilled = tl - fp;

  assign head       = ent[hd_i];
  assign head_valid = head.filled && (count != '0);

  // Slot bookkeeping: flush wins, otherwise alloc/fill/pop touch distinct slots.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      hd <= '0;
      tl <= '0;
      fp <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ent[i] <= '0;
      end
    end else if (flush) begin
      hd <= '0;
      tl <= '0;
      fp <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        ent[i].filled <= 1'b0;
      end
    end else begin
      if (alloc) begin
        ent[tl_i] <= '{
          pc:     PC_W'(alloc_pc),
          instr:  NOP,
          filled: 1'b0
        };
        tl <= tl + ONE;
      end
      if (fill && (unfilled != '0)) begin
        ent[fp_i].instr  <= fill_data;
        ent[fp_i].filled <= 1'b1;
        fp <= fp + ONE;
      end
      if (pop && head_valid) begin
        ent[hd_i].filled <= 1'b0;
        hd <= hd + ONE;
      end
    end
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: PC generator, req/gnt IMEM port, redirect flush.
// Optional misaligned-target trap: FETCH_MISALIGN_TRAP_EN.
module rv_fetch_unit
  import rv_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 10,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                QDEPTH   = 4
) (
  input  logic              CLK,
  input  logic              RSTn,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_fault,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  localparam int PW = ptr_w(QDEPTH);
  localparam int DW = PW + 4;
  localparam logic [PW:0] FULL = (PW+1)'(QDEPTH);

  logic [ADDR_W-1:0] pc;
  logic [DW-1:0]     discard;
  logic [DW-1:0]     disc_tot;
  logic              halt;

  fetch_entry_t head;
  logic         head_valid;
  logic [PW:0]  cnt;
  logic [PW:0]  unf;

  logic gnt_ok;
  logic fill;
  logic pop;

  assign imem_req  = RSTn && !halt && (cnt < FULL) && !redirect;
  assign imem_addr = pc;
  assign gnt_ok    = imem_req && imem_gnt;
  assign fill      = imem_rvalid && (discard == '0) && !redirect;
  assign pop       = if_ready && head_valid && !redirect && !halt;

  assign disc_tot = discard + DW'(unf) + DW'(gnt_ok);

  fetch_queue #(
    .ADDR_W (ADDR_W),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .flush      (redirect),
    .alloc      (gnt_ok),
    .alloc_pc   (pc),
    .fill       (fill),
    .fill_data  (imem_rdata),
    .pop        (pop),
    .head       (head),
    .head_valid (head_valid),
    .count      (cnt),
    .unfilled   (unf)
  );

  // Next fetch address: redirect target, else advance on each grant.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
    end else if (gnt_ok) begin
      pc <= pc + ADDR_W'(4);
    end
  end

  // Wrong-path responses still owed by memory are dropped as they return.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      discard <= '0;
    end else if (redirect) begin
      if (imem_rvalid && (disc_tot != '0)) begin
        discard <= disc_tot - DW'(1);
      end else begin
        discard <= disc_tot;
      end
    end else if (imem_rvalid && (discard != '0)) begin
      discard <= discard - DW'(1);
    end
  end

  // A kept response with no unfilled slot means memory broke the protocol.
  always @(posedge CLK) begin
    if (RSTn && fill) begin
      assert (unf != '0);
    end
  end

  logic unused_head;
  assign unused_head = ^{head.pc, head.filled};

`ifdef FETCH_MISALIGN_TRAP_EN
  logic              fpend;
  logic [ADDR_W-1:0] fpc;

  // Misaligned target parks fetch behind a single fault entry.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      halt  <= 1'b0;
      fpend <= 1'b0;
      fpc   <= '0;
    end else if (redirect) begin
      halt  <= |redirect_pc[1:0];
      fpend <= |redirect_pc[1:0];
      fpc   <= redirect_pc;
    end else if (halt && fpend && if_ready) begin
      fpend <= 1'b0;
    end
  end

  assign if_valid = halt ? fpend : head_valid;
  assign if_fault = halt && fpend;
  assign if_instr = halt ? 32'h0 : head.instr;
  assign if_pc    = halt ? fpc : head.pc[ADDR_W-1:0];
`else
  logic unused_rpc;
  assign unused_rpc = ^redirect_pc[1:0];

  assign halt     = 1'b0;
  assign if_valid = head_valid;
  assign if_fault = 1'b0;
  assign if_instr = head.instr;
  assign if_pc    = head.pc[ADDR_W-1:0];
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// tb_rv_fetch_unit: directed checks of the fetch stage against a
// fixed-latency in-order memory model.
module tb_rv_fetch_unit;

  logic        CLK;
  logic        RSTn;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [9:0]  if_pc;
  logic        if_fault;
  logic        redirect;
  logic [9:0]  redirect_pc;

  rv_fetch_unit #(
    .ADDR_W   (10),
    .RESET_PC (10'h000),
    .QDEPTH   (4)
  ) dut (
    .CLK         (CLK),
    .RSTn        (RSTn),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_fault    (if_fault),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [9:0] addr;
    int         due;
  } req_t;

  req_t pend [$];
  int   cyc;
  int   K;
  int   ngnt;
  int   checks;
  int   errors;

  function automatic logic [31:0] word(input logic [9:0] a);
    return 32'h1000_0000 | {22'd0, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    #1;
    if (imem_req && imem_gnt) begin
      pend.push_back('{addr: imem_addr, due: cyc + K});
      ngnt++;
    end
    @(posedge CLK);
    #1;
    cyc++;
    redirect = 1'b0;
    if (pend.size() != 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ngnt = 0;
    cyc = 0;
    K = 1;
    RSTn = 1'b0;
    if_ready = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = '0;

    step();
    step();
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_fault", 32'(if_fault), 0);
    chk("rst_instr", if_instr, 0);
    chk("rst_pc", 32'(if_pc), 0);

    RSTn = 1'b1;
    cyc = 1;
    #1;
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", 32'(imem_addr), 0);
    step();
    chk("c2_valid", 32'(if_valid), 0);
    chk("c2_addr", 32'(imem_addr), 4);
    step();
    for (int c = 3; c <= 8; c++) begin
      chk("stream_valid", 32'(if_valid), 1);
      chk("stream_pc", 32'(if_pc), 32'(4 * (c - 3)));
      chk("stream_instr", if_instr, word(10'(4 * (c - 3))));
      chk("stream_addr", 32'(imem_addr), 32'(4 * (c - 1)));
      step();
    end

    RSTn = 1'b0;
    #1;
    chk("arst_req", 32'(imem_req), 0);
    chk("arst_valid", 32'(if_valid), 0);
    pend.delete();
    imem_rvalid = 1'b0;
    if_ready = 1'b0;
    step();
    step();
    RSTn = 1'b1;
    cyc = 1;
    ngnt = 0;
    #1;
    repeat (4) step();
    for (int c = 5; c <= 10; c++) begin
      chk("full_noreq", 32'(imem_req), 0);
      chk("hold_valid", 32'(if_valid), 1);
      chk("hold_pc", 32'(if_pc), 0);
      step();
    end
    chk("grants", 32'(ngnt), 4);
    if_ready = 1'b1;
    #1;
    for (int c = 11; c <= 14; c++) begin
      chk("drain_valid", 32'(if_valid), 1);
      chk("drain_pc", 32'(if_pc), 32'(4 * (c - 11)));
      if (c == 12) begin
        chk("resume_req", 32'(imem_req), 1);
        chk("resume_addr", 32'(imem_addr), 32'h10);
      end
      step();
    end
    chk("resume_pc", 32'(if_pc), 32'h10);
    chk("resume_valid", 32'(if_valid), 1);
    step();

    redirect = 1'b1;
    redirect_pc = 10'h3F8;
    #1;
    chk("redir_noreq", 32'(imem_req), 0);
    step();
    chk("wrp_valid0", 32'(if_valid), 0);
    chk("wrp_req", 32'(imem_req), 1);
    chk("wrp_addr0", 32'(imem_addr), 32'h3F8);
    step();
    chk("wrp_addr1", 32'(imem_addr), 32'h3FC);
    chk("wrp_valid1", 32'(if_valid), 0);
    step();
    chk("wrap_addr", 32'(imem_addr), 32'h000);
    chk("wrp_pc0", 32'(if_pc), 32'h3F8);
    chk("wrp_instr0", if_instr, word(10'h3F8));
    step();
    chk("wrp_pc1", 32'(if_pc), 32'h3FC);
    step();
    chk("wrp_pc2", 32'(if_pc), 32'h000);
    chk("wrp_instr2", if_instr, word(10'h000));

    K = 3;
    step();
    repeat (6) step();
    redirect = 1'b1;
    redirect_pc = 10'h100;
    #1;
    chk("k3_redir_noreq", 32'(imem_req), 0);
    step();
    chk("k3_req", 32'(imem_req), 1);
    chk("k3_addr", 32'(imem_addr), 32'h100);
    chk("k3_stale1", 32'(if_valid), 0);
    step();
    for (int i = 2; i <= 4; i++) begin
      chk("k3_stale", 32'(if_valid), 0);
      step();
    end
    chk("k3_valid", 32'(if_valid), 1);
    chk("k3_pc", 32'(if_pc), 32'h100);
    chk("k3_instr", if_instr, word(10'h100));
    step();
    chk("k3_pc1", 32'(if_pc), 32'h104);
    step();
    chk("coin_valid", 32'(if_valid), 1);
    chk("coin_pc", 32'(if_pc), 32'h108);
    redirect = 1'b1;
    redirect_pc = 10'h200;
    #1;
    step();
    chk("coin_flush", 32'(if_valid), 0);
    chk("coin_req", 32'(imem_req), 1);
    chk("coin_addr", 32'(imem_addr), 32'h200);
    step();
    for (int i = 2; i <= 4; i++) begin
      chk("coin_stale", 32'(if_valid), 0);
      step();
    end
    chk("coin_valid2", 32'(if_valid), 1);
    chk("coin_pc2", 32'(if_pc), 32'h200);
    chk("coin_instr2", if_instr, word(10'h200));
    step();

    redirect = 1'b1;
    redirect_pc = 10'h102;
    #1;
    step();
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", 32'(if_fault), 1);
    chk("mis_valid", 32'(if_valid), 1);
    chk("mis_pc", 32'(if_pc), 32'h102);
    chk("mis_instr", if_instr, 0);
    chk("mis_noreq", 32'(imem_req), 0);
    if_ready = 1'b0;
    step();
    chk("mis_hold", 32'(if_fault), 1);
    chk("mis_noreq1", 32'(imem_req), 0);
    if_ready = 1'b1;
    #1;
    step();
    chk("mis_popped", 32'(if_valid), 0);
    chk("mis_halt", 32'(imem_req), 0);
    step();
    chk("mis_halt1", 32'(imem_req), 0);
    redirect = 1'b1;
    redirect_pc = 10'h200;
    #1;
    step();
    chk("mis_resume", 32'(imem_req), 1);
    chk("mis_raddr", 32'(imem_addr), 32'h200);
    chk("mis_clr", 32'(if_fault), 0);
`else
    chk("mis_req", 32'(imem_req), 1);
    chk("mis_align", 32'(imem_addr), 32'h100);
    chk("mis_nofault", 32'(if_fault), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
